// File: rtl/output_writeback_unit.sv
// rtl/output_writeback_unit.sv - requantizes PE results, buffers them and writes them to output memory
// Optional feature: define OWB_RELU_EN to clamp negative activations to zero.
module output_writeback_unit #(
  parameter int BIN_LEN     = 8,
  parameter int OUT_BIN_LEN = 16,
  parameter int OUT_WIDTH   = 6,
  parameter int OUT_HEIGHT  = 6,
  parameter int SHIFT       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [OUT_BIN_LEN-1:0] pe_output_val,
  input  logic                   pe_output_valid,
  input  logic                   pe_done,
  output logic [BIN_LEN-1:0]     mem_wr_data,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic                   mem_wr_valid,
  input  logic                   mem_wr_ready,
  output logic                   overflow,
  output logic                   underrun,
  output logic                   done
);

  localparam int TOTAL = OUT_WIDTH * OUT_HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic signed [OUT_BIN_LEN-1:0] QMAX = OUT_BIN_LEN'((1 << (BIN_LEN - 1)) - 1);
  localparam logic signed [OUT_BIN_LEN-1:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0]   r_accept_cnt;
  logic [ADDR_W-1:0]  r_addr_cnt;
  logic               r_stage_valid;
  logic [BIN_LEN-1:0] r_stage_data;
  logic [ADDR_W-1:0]  r_stage_addr;
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic [BIN_LEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
  logic               r_overflow;
  logic               r_underrun;
  logic               r_done;

  logic                          w_start_frame;
  logic                          w_accept;
  logic                          w_last_accept;
  logic                          w_early;
  logic                          w_fifo_empty;
  logic                          w_fifo_full;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_drop;
  logic signed [OUT_BIN_LEN-1:0] w_shifted;
  logic [BIN_LEN-1:0]            w_quant;

  assign w_start_frame = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept      = (r_state == S_RUN) && pe_output_valid;
  assign w_last_accept = w_accept && (r_accept_cnt == CNT_W'(TOTAL - 1));
  assign w_early       = (r_state == S_RUN) && pe_done && !w_last_accept;

  // MSB of each pointer toggles on wrap: equal low bits with differing MSBs means full
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop        = !w_fifo_empty && mem_wr_ready;
  assign w_push       = r_stage_valid && (!w_fifo_full || w_pop);
  assign w_drop       = r_stage_valid && w_fifo_full && !w_pop;

  always_comb begin
    w_shifted = $signed(pe_output_val) >>> SHIFT;
    if (w_shifted > QMAX) begin
      w_quant = QMAX[BIN_LEN-1:0];
    end else if (w_shifted < QMIN) begin
      w_quant = QMIN[BIN_LEN-1:0];
    end else begin
      w_quant = w_shifted[BIN_LEN-1:0];
    end
`ifdef OWB_RELU_EN
    if (w_quant[BIN_LEN-1]) begin
      w_quant = '0;
    end
`else
`endif
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_RUN;
      S_RUN:          if (w_last_accept || pe_done) w_next_state = S_DRAIN;
      S_DRAIN:        if (!r_stage_valid && w_fifo_empty) w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_done        <= 1'b0;
      r_accept_cnt  <= '0;
      r_addr_cnt    <= '0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_stage_addr  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overflow    <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == S_DONE);
      if (w_start_frame) begin
        r_accept_cnt  <= '0;
        r_addr_cnt    <= '0;
        r_stage_valid <= 1'b0;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_overflow    <= 1'b0;
        r_underrun    <= 1'b0;
      end else begin
        r_stage_valid <= w_accept;
        r_stage_data  <= w_quant;
        r_stage_addr  <= r_addr_cnt;
        if (w_accept) begin
          r_accept_cnt <= r_accept_cnt + CNT_W'(1);
          r_addr_cnt   <= r_addr_cnt + ADDR_W'(1);
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        if (w_drop)  r_overflow <= 1'b1;
        if (w_early) r_underrun <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible once pushed
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= r_stage_data;
      r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= r_stage_addr;
    end
  end

  assign mem_wr_valid = !w_fifo_empty;
  assign mem_wr_data  = mem_wr_valid ? r_fifo_data[r_rd_ptr[PTR_W-1:0]] : '0;
  assign mem_wr_addr  = mem_wr_valid ? r_fifo_addr[r_rd_ptr[PTR_W-1:0]] : '0;
  assign overflow     = r_overflow;
  assign underrun     = r_underrun;
  assign done         = r_done;

endmodule

// File: tb/tb_output_writeback_unit.sv
// tb/tb_output_writeback_unit.sv - directed self-checking bench for output_writeback_unit
module tb_output_writeback_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pe_output_val = '0;
  logic        pe_output_valid = 1'b0;
  logic        pe_done = 1'b0;
  logic [7:0]  mem_wr_data;
  logic [5:0]  mem_wr_addr;
  logic        mem_wr_valid;
  logic        mem_wr_ready = 1'b0;
  logic        overflow;
  logic        underrun;
  logic        done;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_data[$];
  logic [5:0] q_addr[$];
  logic [7:0] exp_neg;

  output_writeback_unit dut (
    .clock(clock), .reset(reset), .start(start),
    .pe_output_val(pe_output_val), .pe_output_valid(pe_output_valid), .pe_done(pe_done),
    .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr), .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready), .overflow(overflow), .underrun(underrun), .done(done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && mem_wr_valid && mem_wr_ready) begin
      q_data.push_back(mem_wr_data);
      q_addr.push_back(mem_wr_addr);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_data.delete();
    q_addr.delete();
  endtask

  initial begin
    int errs;
    int n;
`ifdef OWB_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'hF0;
`endif

    // Reset values
    repeat (2) step();
    chk("rst_valid", 32'(mem_wr_valid), 0);
    chk("rst_data", 32'(mem_wr_data), 0);
    chk("rst_addr", 32'(mem_wr_addr), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b1;
    step();

    // Test 1: basic write latency
    mem_wr_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    pe_output_valid = 1'b1; pe_output_val = 16'h0123; step();
    pe_output_valid = 1'b0;
    chk("t1_valid_t1", 32'(mem_wr_valid), 0);
    step();
    chk("t1_valid_t2", 32'(mem_wr_valid), 1);
    chk("t1_data", 32'(mem_wr_data), 32'h12);
    chk("t1_addr", 32'(mem_wr_addr), 0);

    // Test 2: saturation and negatives
    pe_output_valid = 1'b1; pe_output_val = 16'h7FFF; step();
    pe_output_val = 16'hFF00; step();
    pe_output_valid = 1'b0;
    repeat (3) step();
    chk("t2_count", 32'(q_data.size()), 3);
    chk("t2_sat_pos", 32'(q_data[1]), 32'h7F);
    chk("t2_neg", 32'(q_data[2]), 32'(exp_neg));
    chk("t2_addr", 32'(q_addr[2]), 2);
    pe_done = 1'b1; step(); pe_done = 1'b0;
    chk("t2_underrun", 32'(underrun), 1);
    repeat (3) step();
    chk("t2_done", 32'(done), 1);

    // Test 3: full frame, ready held high
    clear_log();
    start = 1'b1; step(); start = 1'b0;
    chk("t3_done_cleared", 32'(done), 0);
    chk("t3_underrun_cleared", 32'(underrun), 0);
    for (int i = 0; i < 36; i++) begin
      pe_output_valid = 1'b1; pe_output_val = 16'(i * 16); step();
    end
    pe_output_valid = 1'b0;
    step(); step();
    chk("t3_done_early", 32'(done), 0);
    step();
    chk("t3_done", 32'(done), 1);
    chk("t3_count", 32'(q_data.size()), 36);
    errs = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_addr[i] !== 6'(i) || q_data[i] !== 8'(i)) errs++;
    end
    chk("t3_order_errors", 32'(errs), 0);
    chk("t3_overflow", 32'(overflow), 0);

    // Test 4: backpressure and overflow
    clear_log();
    mem_wr_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pe_output_valid = 1'b1; pe_output_val = 16'((i + 1) * 16); step();
    end
    pe_output_valid = 1'b0;
    step();
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_valid", 32'(mem_wr_valid), 1);
    chk("t4_head_addr", 32'(mem_wr_addr), 0);
    chk("t4_head_data", 32'(mem_wr_data), 1);
    step();
    chk("t4_hold_data", 32'(mem_wr_data), 1);
    chk("t4_hold_addr", 32'(mem_wr_addr), 0);
    mem_wr_ready = 1'b1;
    repeat (6) step();
    chk("t4_count", 32'(q_data.size()), 4);
    errs = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_addr[i] !== 6'(i) || q_data[i] !== 8'(i + 1)) errs++;
    end
    chk("t4_order_errors", 32'(errs), 0);
    pe_done = 1'b1; step(); pe_done = 1'b0;
    repeat (3) step();
    chk("t4_done", 32'(done), 1);

    // Test 5: early finish
    clear_log();
    start = 1'b1; step(); start = 1'b0;
    chk("t5_overflow_cleared", 32'(overflow), 0);
    for (int i = 0; i < 10; i++) begin
      pe_output_valid = 1'b1; pe_output_val = 16'(16'h0100 + i * 16); step();
    end
    pe_output_valid = 1'b0;
    pe_done = 1'b1; step(); pe_done = 1'b0;
    chk("t5_underrun", 32'(underrun), 1);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("t5_done", 32'(done), 1);
    chk("t5_count", 32'(q_data.size()), 10);
    chk("t5_last_addr", 32'(q_addr[9]), 9);
    chk("t5_last_data", 32'(q_data[9]), 32'h19);

    // Test 6: reset mid-frame
    clear_log();
    mem_wr_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pe_output_valid = 1'b1; pe_output_val = 16'h0070; step();
    end
    pe_output_valid = 1'b0;
    step();
    chk("t6_queued", 32'(mem_wr_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid_async", 32'(mem_wr_valid), 0);
    chk("t6_done_async", 32'(done), 0);
    #1 reset = 1'b1;
    step();
    mem_wr_ready = 1'b1;
    pe_output_valid = 1'b1; pe_output_val = 16'h0050;
    repeat (3) step();
    pe_output_valid = 1'b0;
    step();
    chk("t6_idle_no_writes", 32'(q_data.size()), 0);
    start = 1'b1; step(); start = 1'b0;
    pe_output_valid = 1'b1; pe_output_val = 16'h0230; step();
    pe_output_valid = 1'b0;
    repeat (3) step();
    chk("t6_restart_count", 32'(q_data.size()), 1);
    chk("t6_restart_addr", 32'(q_addr[0]), 0);
    chk("t6_restart_data", 32'(q_data[0]), 32'h23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_writeback_unit.md
# output_writeback_unit

Downstream stage of the processing unit: consumes the convolution result stream (`output_val`/`output_valid`/`done`), requantizes each `OUT_BIN_LEN`-bit partial sum to a `BIN_LEN`-bit activation, buffers results in a small FIFO, and writes them to output memory over a valid/ready port with a raster-order address. It tracks the frame's result count and raises `done` only once every result has been handed to memory.

## Interface
Parameters:
- `BIN_LEN`, 8: output activation width (signed).
- `OUT_BIN_LEN`, 16: incoming partial-sum width (signed two's complement).
- `OUT_WIDTH`, 6: results per output row.
- `OUT_HEIGHT`, 6: output rows per frame.
- `SHIFT`, 4: arithmetic right shift applied before saturation, 0..`OUT_BIN_LEN`-1.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, at least 2.
- `ADDR_W`, 6: memory address width, at least clog2(`OUT_WIDTH`*`OUT_HEIGHT`).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (already decided). Asserting it (low) forces all state to its reset values immediately.
- `start` in 1: single-cycle frame start pulse.
- `pe_output_val` in `OUT_BIN_LEN`: partial sum from the processing unit.
- `pe_output_valid` in 1: `pe_output_val` is valid this cycle. There is no backpressure to the processing unit.
- `pe_done` in 1: processing unit finished. Used only for the early-finish check.
- `mem_wr_data` out `BIN_LEN`: requantized activation at the FIFO head.
- `mem_wr_addr` out `ADDR_W`: raster address of the FIFO head.
- `mem_wr_valid` out 1: the FIFO is non-empty.
- `mem_wr_ready` in 1: memory accepts the write this cycle.
- `overflow` out 1: sticky flag. A result was dropped because the FIFO was full.
- `underrun` out 1: sticky flag. `pe_done` arrived before `OUT_WIDTH`*`OUT_HEIGHT` results.
- `done` out 1: frame fully written.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset state is IDLE.
- IDLE or DONE, `start`=1: go to RUN. Clear the accept counter, address counter, FIFO, `overflow` and `underrun`.
- `start` is ignored in RUN and DRAIN.
- RUN: each cycle with `pe_output_valid`=1 accepts one result.
  - The result is quantized into a one-entry stage register. The address counter increments.
  - When the accept count reaches `OUT_WIDTH`*`OUT_HEIGHT`, go to DRAIN.
- RUN, `pe_done`=1 with fewer results accepted than expected: set `underrun` and go to DRAIN.
- DRAIN: when the stage register and FIFO are both empty, go to DONE.
- `pe_output_valid` is ignored outside RUN.
- Quantization: q = `pe_output_val` >>> `SHIFT` (arithmetic shift), then saturate to [-2^(`BIN_LEN`-1), 2^(`BIN_LEN`-1)-1].
- Address = row*`OUT_WIDTH`+col, in accept order, starting at 0. Each FIFO entry stores its address together with its data.
- FIFO push: the stage register is valid and the FIFO is not full, or is full with a pop in the same cycle. A push and pop in the same cycle keeps the occupancy unchanged.
- Stage register valid while the FIFO is full and no pop occurs: drop the result and set `overflow`. The address of the dropped result is still consumed.
- FIFO pop: `mem_wr_valid` && `mem_wr_ready`.
- Read and write pointers wrap modulo `FIFO_DEPTH`. A pointer-MSB scheme distinguishes full from empty.

## Timing
- Reset values: `mem_wr_valid`=0, `mem_wr_data`=0, `mem_wr_addr`=0, `overflow`=0, `underrun`=0, `done`=0.
- Latency: a result accepted in cycle t sits in the stage register in cycle t+1. With room in the FIFO, it appears as `mem_wr_valid`=1 in cycle t+2.
- `mem_wr_data` and `mem_wr_addr` hold stable while `mem_wr_valid`=1 and `mem_wr_ready`=0.
- Sustained throughput is one result per cycle when `mem_wr_ready` stays high.
- `done` is registered. It is high from the cycle after entering DONE until the cycle after the next `start`.
- Reset asserted mid-frame: the FIFO is discarded, the FSM returns to IDLE and no further writes are issued.

## Configuration
- `OWB_RELU_EN` defined: after saturation, negative q is forced to 0, so the output range is [0, 2^(`BIN_LEN`-1)-1].
- `OWB_RELU_EN` undefined: the signed saturated value is passed through unchanged.

## Test plan
- Test 1, basic write: `start`, then `pe_output_val`=0x0123 valid for 1 cycle, `mem_wr_ready`=1. Expected: `mem_wr_valid` 2 cycles later with `mem_wr_data`=0x12 and `mem_wr_addr`=0.
- Test 2, saturation and negatives: inputs 0x7FFF then 0xFF00. Expected: `mem_wr_data` 0x7F then 0xF0. With `OWB_RELU_EN` defined, 0x7F then 0x00.
- Test 3, full frame: 36 back-to-back valid results with ready held high. Expected: addresses 0..35 in order, `done`=1 two cycles after the last write, `overflow`=0.
- Test 4, backpressure: `mem_wr_ready`=0 while 5 results arrive. Expected: 4 are buffered, the 5th is dropped, `overflow`=1. When ready is raised, addresses 0,1,2,3 are written and address 4 is never written.
- Test 5, early finish: `pe_done` after 10 results. Expected: `underrun`=1, 10 writes, then `done`=1.
- Test 6, reset mid-frame: assert `reset` low during RUN with 3 results queued. Expected: `mem_wr_valid`=0 immediately and the FSM in IDLE. A subsequent `start` restarts at address 0.
